// File: rtl/msrv32_hpm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_hpm_pkg
//  Description : Shared constants and helpers for the machine counter bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package msrv32_hpm_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
    localparam logic [11:0] CSR_INDEX_MASK    = 12'h01F;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam int OF_BIT       = 31;
    localparam int INH_CY       = 0;
    localparam int INH_IR       = 2;
    localparam int INH_HPM_BASE = 3;

    function automatic int sel_width(input int num_events);
        return $clog2(num_events + 1);
    endfunction

    function automatic logic [31:0] csr_merge(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] operand);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_hpm_counter.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_hpm_counter
//  Description : One wide counter with optional event selector and OF flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_hpm_counter
    import msrv32_hpm_pkg::*;
#(
    parameter int CTR_WIDTH  = 64,
    parameter int NUM_EVENTS = 8,
    parameter int HAS_EVENT  = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  inhibit,
    input  logic                  direct_inc,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic [1:0]            op,
    input  logic [31:0]           operand,
    input  logic                  wr_lo,
    input  logic                  wr_hi,
    input  logic                  wr_evt,
    output logic [CTR_WIDTH-1:0]  count,
    output logic [31:0]           evt_reg,
    output logic                  of_flag
);

    localparam int SEL_W = sel_width(NUM_EVENTS);
    localparam int HI_W  = CTR_WIDTH - 32;
    localparam logic [CTR_WIDTH-1:0] C_ONE = 1;

    logic [CTR_WIDTH-1:0] r_cnt;
    logic                 w_inc;
    logic                 w_inc_en;
    logic                 w_wrap;
    logic [31:0]          w_hi_old;
    logic [31:0]          w_lo_new;
    logic [31:0]          w_hi_new;

    assign w_hi_old = 32'(r_cnt[CTR_WIDTH-1:32]);
    assign w_lo_new = csr_merge(op, r_cnt[31:0], operand);
    assign w_hi_new = csr_merge(op, w_hi_old, operand);
    // A software write to either half suppresses this cycle's increment
    assign w_inc_en = w_inc & ~inhibit & ~wr_lo & ~wr_hi;
    assign w_wrap   = w_inc_en & (&r_cnt);
    assign count    = r_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) r_cnt[31:0]           <= w_lo_new;
            if (wr_hi) r_cnt[CTR_WIDTH-1:32] <= w_hi_new[HI_W-1:0];
        end else if (w_inc_en) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    if (HAS_EVENT != 0) begin : g_evt
        logic [SEL_W-1:0] r_sel;
        logic             r_of;
        logic             w_evt_hit;
        logic [31:0]      w_evt_new;
        logic             w_unused_direct;

        assign w_unused_direct = direct_inc;

        // sel = 0 or beyond the event count never matches
        always_comb begin
            w_evt_hit = 1'b0;
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if (r_sel == SEL_W'(k)) w_evt_hit = event_vec[k-1];
            end
        end

        always_comb begin
            evt_reg              = '0;
            evt_reg[SEL_W-1:0]   = r_sel;
            evt_reg[OF_BIT]      = r_of;
        end

        assign w_evt_new = csr_merge(op, evt_reg, operand);
        assign w_inc     = w_evt_hit;
        assign of_flag   = r_of;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_sel <= '0;
                r_of  <= 1'b0;
            end else if (wr_evt) begin
                r_sel <= w_evt_new[SEL_W-1:0];
                r_of  <= w_evt_new[OF_BIT] | w_wrap;
            end else begin
                r_of  <= r_of | w_wrap;
            end
        end
    end else begin : g_no_evt
        logic w_unused_evt;

        assign w_unused_evt = ^{event_vec, wr_evt, w_wrap};
        assign w_inc        = direct_inc;
        assign evt_reg      = '0;
        assign of_flag      = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/msrv32_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_hpm_counter_bank
//  Description : mcycle/minstret, NUM_HPM perf counters and mcountinhibit.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_hpm_counter_bank
    import msrv32_hpm_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CTR_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en_in,
    input  logic [11:0]           csr_addr_in,
    input  logic [2:0]            csr_op_in,
    input  logic [4:0]            csr_uimm_in,
    input  logic [31:0]           csr_data_in,
    input  logic                  instret_inc_in,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic [31:0]           csr_data_out,
    output logic                  csr_hit_out,
    output logic                  csr_ro_out,
    output logic                  ovf_irq_out,
    output logic [NUM_HPM-1:0]    ovf_vec_out
);

    localparam logic [31:0] C_INH_MASK = (32'h1 << INH_CY) | (32'h1 << INH_IR)
                                       | (((32'h1 << NUM_HPM) - 32'h1) << INH_HPM_BASE);
    localparam logic [4:0] C_IDX_CY  = CSR_MCYCLE[4:0];
    localparam logic [4:0] C_IDX_IR  = CSR_MINSTRET[4:0];
    localparam logic [4:0] C_IDX_HPM = CSR_MHPMCOUNTER3[4:0];

    logic [31:0]          r_inh;
    logic [31:0]          w_operand;
    logic                 w_wr_cmd;
    logic [11:0]          w_base;
    logic [4:0]           w_idx;
    logic                 w_is_hi;
    logic                 w_ctr_region;
    logic                 w_shd_region;
    logic                 w_is_inh;
    logic                 w_idx_impl;
    logic                 w_evt_impl;
    logic [CTR_WIDTH-1:0] w_ctr_val;
    logic [63:0]          w_ctr_val64;
    logic [31:0]          w_evt_val;
    logic                 w_ctr_wr;
    logic                 w_cy_wr_lo, w_cy_wr_hi, w_ir_wr_lo, w_ir_wr_hi;
    logic [NUM_HPM-1:0]   w_hpm_wr_lo, w_hpm_wr_hi, w_hpm_wr_evt;
    logic [CTR_WIDTH-1:0] w_cy_cnt, w_ir_cnt;
    logic [CTR_WIDTH-1:0] w_hpm_cnt [NUM_HPM];
    logic [31:0]          w_hpm_evt [NUM_HPM];
    logic [31:0]          w_unused_cy_evt, w_unused_ir_evt;
    logic                 w_unused_cy_of, w_unused_ir_of;

    assign w_operand    = csr_op_in[2] ? {27'b0, csr_uimm_in} : csr_data_in;
    assign w_wr_cmd     = wr_en_in && (csr_op_in[1:0] != CSR_OP_NONE);
    // Counter and shadow pages share one layout: bit 7 = hi half, [4:0] = index
    assign w_base       = csr_addr_in & ~(CSR_HI_OFFSET | CSR_INDEX_MASK);
    assign w_idx        = csr_addr_in[4:0];
    assign w_is_hi      = |(csr_addr_in & CSR_HI_OFFSET);
    assign w_ctr_region = (w_base == CSR_MCYCLE);
    assign w_shd_region = (w_base == CSR_CYCLE);
    assign w_is_inh     = (csr_addr_in == CSR_MCOUNTINHIBIT);
    assign w_ctr_wr     = w_wr_cmd && w_ctr_region && w_idx_impl;

    always_comb begin
        w_idx_impl   = 1'b0;
        w_ctr_val    = '0;
        w_evt_impl   = 1'b0;
        w_evt_val    = '0;
        w_hpm_wr_lo  = '0;
        w_hpm_wr_hi  = '0;
        w_hpm_wr_evt = '0;
        if (w_idx == C_IDX_CY) begin
            w_idx_impl = 1'b1;
            w_ctr_val  = w_cy_cnt;
        end
        if (w_idx == C_IDX_IR) begin
            w_idx_impl = 1'b1;
            w_ctr_val  = w_ir_cnt;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (w_idx == C_IDX_HPM + 5'(i)) begin
                w_idx_impl     = 1'b1;
                w_ctr_val      = w_hpm_cnt[i];
                w_hpm_wr_lo[i] = w_wr_cmd && w_ctr_region && !w_is_hi;
                w_hpm_wr_hi[i] = w_wr_cmd && w_ctr_region && w_is_hi;
            end
            if (csr_addr_in == CSR_MHPMEVENT3 + 12'(i)) begin
                w_evt_impl      = 1'b1;
                w_evt_val       = w_hpm_evt[i];
                w_hpm_wr_evt[i] = w_wr_cmd;
            end
        end
    end

    assign w_cy_wr_lo = w_ctr_wr && (w_idx == C_IDX_CY) && !w_is_hi;
    assign w_cy_wr_hi = w_ctr_wr && (w_idx == C_IDX_CY) && w_is_hi;
    assign w_ir_wr_lo = w_ctr_wr && (w_idx == C_IDX_IR) && !w_is_hi;
    assign w_ir_wr_hi = w_ctr_wr && (w_idx == C_IDX_IR) && w_is_hi;

    assign w_ctr_val64 = 64'(w_ctr_val);

    always_comb begin
        csr_data_out = '0;
        if (w_is_inh)   csr_data_out = r_inh;
        if (w_evt_impl) csr_data_out = w_evt_val;
        if ((w_ctr_region || w_shd_region) && w_idx_impl)
            csr_data_out = w_is_hi ? w_ctr_val64[63:32] : w_ctr_val64[31:0];
    end

    assign csr_hit_out = w_is_inh || w_evt_impl || ((w_ctr_region || w_shd_region) && w_idx_impl);
    assign csr_ro_out  = w_shd_region && w_idx_impl;
    assign ovf_irq_out = |ovf_vec_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_inh <= '0;
        end else if (w_wr_cmd && w_is_inh) begin
            r_inh <= csr_merge(csr_op_in[1:0], r_inh, w_operand) & C_INH_MASK;
        end
    end

    msrv32_hpm_counter #(
        .CTR_WIDTH (CTR_WIDTH),
        .NUM_EVENTS(NUM_EVENTS),
        .HAS_EVENT (0)
    ) u_mcycle (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inhibit   (r_inh[INH_CY]),
        .direct_inc(1'b1),
        .event_vec ('0),
        .op        (csr_op_in[1:0]),
        .operand   (w_operand),
        .wr_lo     (w_cy_wr_lo),
        .wr_hi     (w_cy_wr_hi),
        .wr_evt    (1'b0),
        .count     (w_cy_cnt),
        .evt_reg   (w_unused_cy_evt),
        .of_flag   (w_unused_cy_of)
    );

    msrv32_hpm_counter #(
        .CTR_WIDTH (CTR_WIDTH),
        .NUM_EVENTS(NUM_EVENTS),
        .HAS_EVENT (0)
    ) u_minstret (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inhibit   (r_inh[INH_IR]),
        .direct_inc(instret_inc_in),
        .event_vec ('0),
        .op        (csr_op_in[1:0]),
        .operand   (w_operand),
        .wr_lo     (w_ir_wr_lo),
        .wr_hi     (w_ir_wr_hi),
        .wr_evt    (1'b0),
        .count     (w_ir_cnt),
        .evt_reg   (w_unused_ir_evt),
        .of_flag   (w_unused_ir_of)
    );

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
        msrv32_hpm_counter #(
            .CTR_WIDTH (CTR_WIDTH),
            .NUM_EVENTS(NUM_EVENTS),
            .HAS_EVENT (1)
        ) u_hpm (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .inhibit   (r_inh[INH_HPM_BASE+i]),
            .direct_inc(1'b0),
            .event_vec (event_in),
            .op        (csr_op_in[1:0]),
            .operand   (w_operand),
            .wr_lo     (w_hpm_wr_lo[i]),
            .wr_hi     (w_hpm_wr_hi[i]),
            .wr_evt    (w_hpm_wr_evt[i]),
            .count     (w_hpm_cnt[i]),
            .evt_reg   (w_hpm_evt[i]),
            .of_flag   (ovf_vec_out[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/msrv32_hpm_counter_bank.md
Name: msrv32_hpm_counter_bank

Overview:
Parametrised machine counter bank that supersedes the fixed mcycle/minstret counter pair in the CSR file. It holds:
- mcycle and minstret;
- NUM_HPM programmable hardware performance counters, each with an mhpmevent selector;
- mcountinhibit.

Counters have configurable width and per-counter overflow flags, and the block drives an overflow interrupt request. It sits beside the CSR file's data mux: the CSR file presents the CSR access, and this block returns read data and a hit flag.

Parameters:
NUM_HPM, 4, number of mhpmcounter/mhpmevent pairs starting at index 3 (legal 1..29)
CTR_WIDTH, 64, implemented counter width (legal 33..64); bits above CTR_WIDTH-1 read as 0
NUM_EVENTS, 8, number of event inputs (legal 1..255)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous, active-high reset
wr_en_in  input  1  CSR write strobe for this cycle
csr_addr_in  input  12  CSR address
csr_op_in  input  3  CSR op: [1:0] 01=write, 10=set, 11=clear, 00=no write; [2]=1 selects zero-extended uimm as the operand
csr_uimm_in  input  5  immediate operand
csr_data_in  input  32  rs1 operand
instret_inc_in  input  1  one instruction retired this cycle
event_in  input  NUM_EVENTS  one-cycle event pulses; bit k is event k+1
csr_data_out  output  32  combinational read data for csr_addr_in
csr_hit_out  output  1  csr_addr_in maps to this block
csr_ro_out  output  1  csr_addr_in is a read-only user shadow (0xC00..0xC9F)
ovf_irq_out  output  1  OR of all mhpmevent OF bits
ovf_vec_out  output  NUM_HPM  per-counter OF bits

Behaviour:
- Address map:
  - mcountinhibit 0x320.
  - mhpmevent3+i at 0x323+i.
  - mcycle 0xB00/0xB80 (lo/hi), minstret 0xB02/0xB82.
  - mhpmcounter3+i at 0xB03+i / 0xB83+i.
  - User shadows: 0xC00/0xC02/0xC03+i (lo) and 0xC80/0xC82/0xC83+i (hi).
  - Unimplemented indices inside these ranges: csr_hit_out=0, csr_data_out=0.
- Write data:
  - operand = op[2] ? {27'b0,uimm} : csr_data_in.
  - new = write ? operand : set ? (old | operand) : clear ? (old & ~operand).
  - A commit occurs only when wr_en_in=1, op[1:0]!=00 and the address is a writable hit.
  - Writes to shadows are ignored.
- mcountinhibit:
  - Writable bits are 0 (CY), 2 (IR) and 3..3+NUM_HPM-1.
  - All other bits read 0.
- mhpmevent:
  - Bit 31 is OF, software read/write.
  - Bits [SEL_W-1:0] are the event select, SEL_W=$clog2(NUM_EVENTS+1).
  - Other bits read 0.
  - sel=0 or sel>NUM_EVENTS counts nothing; sel=k counts event_in[k-1].
- Increment rules, applied each cycle:
  - mcycle +1 unless CY=1.
  - minstret +1 if instret_inc_in=1 and IR=1 is not set.
  - hpm i +1 if its selected event is 1 and its inhibit bit is 0.
  - Maximum increment is 1 per cycle.
- Counter arithmetic:
  - Counters are CTR_WIDTH bits and wrap modulo 2^CTR_WIDTH.
  - An hpm wrap (all-ones -> 0) sets that counter's OF in the same edge.
  - mcycle/minstret have no OF.
- Hi/lo writes:
  - A lo write replaces bits [31:0] only; a hi write replaces bits [CTR_WIDTH-1:32] only, and excess operand bits are dropped.
  - In either case the other half is retained.
- Simultaneous events:
  - A CSR write to any half of a counter wins; that counter does not increment that cycle.
  - A write to mhpmevent in the same cycle as a wrap: OF takes the value written | wrap-set.
  - A write that sets an inhibit bit takes effect from the next cycle; the current cycle's increment still uses the old inhibit value.
- Read path:
  - csr_data_out is combinational, zero latency.
  - Written values are visible on the cycle after the commit.
- Reset: all counters, mhpmevent registers and mcountinhibit go to 0, so ovf_irq_out=0 and ovf_vec_out=0. Reset overrides any in-flight write or increment.

Decomposition:
- Package msrv32_hpm_pkg holds:
  - CSR address constants (base addresses and hi offset 0x80);
  - csr_op encodings;
  - OF bit position;
  - mcountinhibit bit indices;
  - the SEL_W function.
- Sub-module msrv32_hpm_counter implements one counter plus its event register, write-merge, wrap/OF logic and inhibit. It is instantiated NUM_HPM times in a generate loop; mcycle/minstret reuse it with the event tied off.

Test Plan:
- Reset, then idle 10 cycles -> mcycle=10, minstret=0, all hpm=0, ovf_irq_out=0. Read of 0x320 returns 0; read of 0xB1F (unimplemented) gives hit=0, data=0.
- Write mhpmevent3=1, pulse event_in[0] 5 times with instret_inc_in high 3 cycles -> 0xB03 reads 5, 0xB02 reads 3, 0xC03 reads 5 with csr_ro_out=1.
- Write 0xB83=0xFFFFFFFF, 0xB03=0xFFFFFFFE, then 3 event pulses -> counter reads 1, OF=1, ovf_irq_out=1, ovf_vec_out[0]=1. A clear op on 0x323 with operand 0x80000000 -> ovf_irq_out=0.
- Set op on 0x320 with uimm=5 -> mcycle and minstret frozen; a clear op with uimm=1 -> mcycle resumes, minstret stays frozen.
- Write 0xB03=100 in the same cycle as an event pulse -> reads 100 the next cycle, not 101. A write to 0xC03 leaves the counter unchanged.
- CTR_WIDTH=40: write 0xB83=0xFFFFFFFF -> read 0xB83=0x000000FF. From all-ones plus 1 event -> wraps to 0 with OF=1. Assert rst_in mid-count -> all values 0 on the next cycle.
